// File: rtl/aes_link_slave_if.sv
// aes_link_slave_if: platform byte link plus AES core handshake seen by aes_link_slave
interface aes_link_slave_if;
    logic [8:0]   bus_in;
    logic         enc_i;
    logic [8:0]   bus_out;
    logic         core_start;
    logic         core_enc;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy;
    logic         frame_err;
    modport slave (
        input  bus_in, enc_i, core_done, core_result,
        output bus_out, core_start, core_enc, core_key, core_text, busy, frame_err
    );
    modport master (
        output bus_in, enc_i, core_done, core_result,
        input  bus_out, core_start, core_enc, core_key, core_text, busy, frame_err
    );
endinterface

// File: rtl/aes_link_slave.sv
// aes_link_slave: collects a 32-byte key/text frame, starts the AES core and streams its 16-byte result back
module aes_link_slave #(
    parameter int TX_GAP     = 3,
    parameter int RX_TIMEOUT = 1000
) (
    input logic             clk,
    input logic             rst,
    aes_link_slave_if.slave lk
);
    localparam int IW = $clog2(RX_TIMEOUT + 1);
    localparam int GW = TX_GAP > 1 ? $clog2(TX_GAP) : 1;
    typedef enum logic [2:0] {ST_RX, ST_START, ST_WAIT, ST_TX_BYTE, ST_TX_GAP} state_t;
    state_t         state, state_nx;
    logic [4:0]     cnt;
    logic [IW-1:0]  idle;
    logic [GW-1:0]  gap;
    logic [3:0]     idx;
    logic [255:0]   shreg, sh_nx;
    logic [127:0]   txreg;
    logic           valid, timeout, last_gap;
    assign valid    = lk.bus_in[8];
    assign sh_nx    = {shreg[247:0], lk.bus_in[7:0]};
    assign timeout  = state == ST_RX && cnt != 5'd0 && idle == IW'(RX_TIMEOUT);
    assign last_gap = gap == GW'(TX_GAP - 1);
    always_ff @(posedge clk) state <= rst ? ST_RX : state_nx;
    // idx has wrapped back to 0 once the 16th byte has gone out
    always_comb begin
        lk.bus_out    = !rst && state == ST_TX_BYTE ? {1'b1, txreg[127:120]} : 9'h000;
        lk.core_start = !rst && state == ST_START;
        lk.busy       = !rst && state != ST_RX;
        lk.frame_err  = !rst && ((valid && state != ST_RX) || timeout);
        state_nx      = state;
        case (state)
            ST_RX:      state_nx = valid && !timeout && cnt == 5'd31 ? ST_START : ST_RX;
            ST_START:   state_nx = ST_WAIT;
            ST_WAIT:    state_nx = lk.core_done ? ST_TX_BYTE : ST_WAIT;
            ST_TX_BYTE: state_nx = TX_GAP != 0 ? ST_TX_GAP : (idx == 4'd15 ? ST_RX : ST_TX_BYTE);
            ST_TX_GAP:  state_nx = !last_gap ? ST_TX_GAP : (idx == 4'd0 ? ST_RX : ST_TX_BYTE);
            default:    state_nx = ST_RX;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idle         <= '0;
            gap          <= '0;
            idx          <= '0;
            shreg        <= '0;
            txreg        <= '0;
            lk.core_key  <= '0;
            lk.core_text <= '0;
            lk.core_enc  <= 1'b0;
        end else begin
            case (state)
                ST_RX: begin
                    idle <= valid || cnt == 5'd0 ? '0 : (idle == IW'(RX_TIMEOUT) ? idle : idle + IW'(1));
                    if (valid) shreg <= sh_nx;
                    // a byte landing on the timeout cycle opens a fresh frame
                    if (timeout) cnt <= valid ? 5'd1 : 5'd0;
                    else if (valid) begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            lk.core_enc  <= lk.enc_i;
                            lk.core_key  <= sh_nx[255:128];
                            lk.core_text <= sh_nx[127:0];
                        end
                    end
                end
                ST_WAIT: if (lk.core_done) begin
                    txreg <= lk.core_result;
                    idx   <= '0;
                end
                ST_TX_BYTE: begin
                    txreg <= {txreg[119:0], 8'h00};
                    idx   <= idx + 4'd1;
                    gap   <= '0;
                end
                ST_TX_GAP: gap <= gap + GW'(1);
                default: ;
            endcase
        end
    end
endmodule
